// File: rtl/usb_tx_packet_compiler.sv
// Builds one USB transmit packet (SYNC, PID, payload, CRC16) into a wide
// parallel vector, stepping through fields as the TX controller state advances.
module usb_tx_packet_compiler (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [2:0]   c_state_TX,
  input  logic [6:0]   Buffer_Occupancy,
  input  logic [7:0]   TX_Packet_Data,
  input  logic [3:0]   pID,
  output logic         copy_signal,
  output logic         Get_TX_Packet_Data,
  output logic         packet_load_complete_TX,
  output logic [9:0]   packet_counter_TX,
  output logic [543:0] packet_TX
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PID  = 3'd2,
    ST_EOP  = 3'd3,
    ST_DATA = 3'd4,
    ST_CRC  = 3'd5
  } tx_state_e;

  tx_state_e   state;
  logic [15:0] crc;
  logic        crc_done;
  logic        eop_seen;

  assign state = tx_state_e'(c_state_TX);

  // USB CRC16 (x^16+x^15+x^2+1) in reflected form, so bits are consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // NOTE: the pop request is combinational so the buffer pops on the same edge
  // that appends the byte; registering it would lose or duplicate a byte.
  assign Get_TX_Packet_Data = (state == ST_DATA) && (Buffer_Occupancy != 7'd0) &&
                              (packet_counter_TX <= 10'd520);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; the async reset clears the whole packet image.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      packet_TX               <= '0;
      packet_counter_TX       <= '0;
      crc                     <= 16'hFFFF;
      crc_done                <= 1'b0;
      eop_seen                <= 1'b0;
      copy_signal             <= 1'b0;
      packet_load_complete_TX <= 1'b0;
    end else begin
      copy_signal <= 1'b0;
      case (state)
        ST_IDLE: begin
          packet_TX               <= '0;
          packet_counter_TX       <= '0;
          crc                     <= 16'hFFFF;
          crc_done                <= 1'b0;
          eop_seen                <= 1'b0;
          packet_load_complete_TX <= 1'b0;
        end
        // SYNC and PID write absolute positions so lingering in them is harmless.
        ST_SYNC: begin
          packet_TX[7:0]    <= 8'h80;
          packet_counter_TX <= 10'd8;
        end
        ST_PID: begin
          packet_TX[15:8]   <= {~pID, pID};
          packet_counter_TX <= 10'd16;
        end
        ST_DATA: begin
          if (Get_TX_Packet_Data) begin
            packet_TX[packet_counter_TX +: 8] <= TX_Packet_Data;
            packet_counter_TX                 <= packet_counter_TX + 10'd8;
            crc                               <= crc16_byte(crc, TX_Packet_Data);
          end
        end
        ST_CRC: begin
          if (!crc_done && (packet_counter_TX <= 10'd528)) begin
            packet_TX[packet_counter_TX +: 16] <= ~crc;
            packet_counter_TX                  <= packet_counter_TX + 10'd16;
            crc_done                           <= 1'b1;
          end
        end
        ST_EOP: begin
          copy_signal             <= !eop_seen;
          eop_seen                <= 1'b1;
          packet_load_complete_TX <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packet_compiler.sv
// Scoreboard bench for usb_tx_packet_compiler: a cycle model pushes expected
// register values per driven cycle, popped and compared after the clock edge.
module tb_usb_tx_packet_compiler;

  logic         clk;
  logic         n_rst;
  logic [2:0]   c_state_TX;
  logic [6:0]   Buffer_Occupancy;
  logic [7:0]   TX_Packet_Data;
  logic [3:0]   pID;
  logic         copy_signal;
  logic         Get_TX_Packet_Data;
  logic         packet_load_complete_TX;
  logic [9:0]   packet_counter_TX;
  logic [543:0] packet_TX;

  usb_tx_packet_compiler dut (
    .clk                    (clk),
    .n_rst                  (n_rst),
    .c_state_TX             (c_state_TX),
    .Buffer_Occupancy       (Buffer_Occupancy),
    .TX_Packet_Data         (TX_Packet_Data),
    .pID                    (pID),
    .copy_signal            (copy_signal),
    .Get_TX_Packet_Data     (Get_TX_Packet_Data),
    .packet_load_complete_TX(packet_load_complete_TX),
    .packet_counter_TX      (packet_counter_TX),
    .packet_TX              (packet_TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [543:0] pkt;
    logic [9:0]   cnt;
    logic         copy;
    logic         cmp;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int get_seen;
  int copy_seen;

  logic [543:0] m_pkt;
  logic [9:0]   m_cnt;
  logic [15:0]  m_crc;
  logic         m_crc_done, m_eop, m_copy, m_cmp;
  logic [7:0]   payload[$];

  task automatic check(input string tag, input logic [543:0] got, input logic [543:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_field(input logic [7:0] bytes[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bytes[i]) c = crc_bits(c, bytes[i]);
    return ~c;
  endfunction

  task automatic model_reset();
    m_pkt = '0; m_cnt = '0; m_crc = 16'hFFFF;
    m_crc_done = 1'b0; m_eop = 1'b0; m_copy = 1'b0; m_cmp = 1'b0;
  endtask

  task automatic step(input logic [2:0] st, input logic [6:0] occ,
                      input logic [7:0] dat, input logic [3:0] pid);
    exp_t e;
    logic mg;
    @(negedge clk);
    c_state_TX = st; Buffer_Occupancy = occ; TX_Packet_Data = dat; pID = pid;
    #1;
    mg = (st == 3'd4) && (occ != 7'd0) && (m_cnt <= 10'd520);
    check("get", {543'd0, Get_TX_Packet_Data}, {543'd0, mg});
    if (Get_TX_Packet_Data) get_seen++;
    m_copy = 1'b0;
    case (st)
      3'd0: model_reset();
      3'd1: begin m_pkt[7:0] = 8'h80; m_cnt = 10'd8; end
      3'd2: begin m_pkt[15:8] = {~pid, pid}; m_cnt = 10'd16; end
      3'd4: if (mg) begin
        m_pkt[m_cnt +: 8] = dat; m_cnt = m_cnt + 10'd8; m_crc = crc_bits(m_crc, dat);
      end
      3'd5: if (!m_crc_done) begin
        m_pkt[m_cnt +: 16] = ~m_crc; m_cnt = m_cnt + 10'd16; m_crc_done = 1'b1;
      end
      3'd3: begin m_copy = !m_eop; m_eop = 1'b1; m_cmp = 1'b1; end
      default: ;
    endcase
    e = '{pkt: m_pkt, cnt: m_cnt, copy: m_copy, cmp: m_cmp};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pkt",  packet_TX, e.pkt);
    check("cnt",  {534'd0, packet_counter_TX}, {534'd0, e.cnt});
    check("copy", {543'd0, copy_signal}, {543'd0, e.copy});
    check("cmp",  {543'd0, packet_load_complete_TX}, {543'd0, e.cmp});
    if (copy_signal) copy_seen++;
  endtask

  initial begin
    logic [7:0] b;
    c_state_TX = 3'd0; Buffer_Occupancy = '0; TX_Packet_Data = '0; pID = '0;
    n_rst = 1'b0;
    model_reset();
    #12;
    check("rst_pkt",  packet_TX, '0);
    check("rst_cnt",  {534'd0, packet_counter_TX}, '0);
    check("rst_copy", {543'd0, copy_signal}, '0);
    check("rst_cmp",  {543'd0, packet_load_complete_TX}, '0);
    check("rst_get",  {543'd0, Get_TX_Packet_Data}, '0);
    n_rst = 1'b1;

    // ACK handshake
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(2, 0, 0, 4'b0010);
    copy_seen = 0;
    for (int i = 0; i < 4; i++) step(3, 0, 0, 4'b0010);
    check("ack_field", {528'd0, packet_TX[15:0]}, {528'd0, 16'hD280});
    check("ack_cnt",   {534'd0, packet_counter_TX}, {534'd0, 10'd16});
    check("ack_copy1", copy_seen, 1);
    check("ack_cmp",   {543'd0, packet_load_complete_TX}, {543'd0, 1'b1});
    step(0, 0, 0, 0);
    check("ack_idle",  {543'd0, packet_load_complete_TX}, '0);

    // DATA0 with held SYNC, an unused-state gap, empty-buffer cycle and held CRC
    payload = '{8'h00, 8'hFF, 8'hAA, 8'h88};
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(2, 0, 0, 4'b0011);
    get_seen = 0;
    step(4, 7'd4, payload[0], 4'b0011);
    step(6, 7'd3, 8'h5A, 4'b0011);
    for (int i = 1; i < 4; i++) step(4, 7'(4 - i), payload[i], 4'b0011);
    step(4, 7'd0, 8'h77, 4'b0011);
    check("d0_get", get_seen, 4);
    step(5, 0, 0, 0); step(5, 0, 0, 0);
    copy_seen = 0;
    step(3, 0, 0, 0); step(3, 0, 0, 0);
    check("d0_data", {512'd0, packet_TX[47:16]}, {512'd0, 32'h88AAFF00});
    check("d0_cnt",  {534'd0, packet_counter_TX}, {534'd0, 10'd64});
    check("d0_crc",  {528'd0, packet_TX[63:48]}, {528'd0, crc_field(payload)});
    check("d0_copy1", copy_seen, 1);

    // Zero-length DATA packet
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(2, 0, 0, 4'b1011);
    step(5, 0, 0, 0); step(3, 0, 0, 0);
    check("z_crc", {528'd0, packet_TX[31:16]}, '0);
    check("z_cnt", {534'd0, packet_counter_TX}, {534'd0, 10'd32});

    // Full 64-byte payload plus extra DATA cycles that must not pull
    payload = {};
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(2, 0, 0, 4'b0011);
    get_seen = 0;
    for (int i = 0; i < 67; i++) begin
      b = 8'($urandom);
      if (i < 64) payload.push_back(b);
      step(4, (i < 64) ? 7'(64 - i) : 7'd5, b, 4'b0011);
    end
    check("full_get", get_seen, 64);
    check("full_cnt_pre", {534'd0, packet_counter_TX}, {534'd0, 10'd528});
    step(5, 0, 0, 0);
    check("full_cnt_post", {534'd0, packet_counter_TX}, {534'd0, 10'd544});
    check("full_crc", {528'd0, packet_TX[543:528]}, {528'd0, crc_field(payload)});
    step(3, 0, 0, 0);

    // Asynchronous reset in the middle of DATA
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(2, 0, 0, 4'b0011);
    for (int i = 0; i < 3; i++) step(4, 7'd10, 8'(8'hC0 + i), 4'b0011);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_pkt", packet_TX, '0);
    check("arst_cnt", {534'd0, packet_counter_TX}, '0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
